// File: rtl/program_loader_pkg.sv
// Shared types and frame constants for the byte-stream program loader.
package program_loader_pkg;

    // Frame field widths
    localparam int COUNT_WIDTH = 16;
    localparam int BYTE_WIDTH  = 8;

    // Default start-of-frame marker
    localparam logic [BYTE_WIDTH-1:0] HEADER_BYTE_DEFAULT = 8'hA5;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COUNT_HI = 3'd1,
        ST_COUNT_LO = 3'd2,
        ST_DATA     = 3'd3,
        ST_CHECK    = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERROR    = 3'd6
    } state_e;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian word assembler: collects bytes MSB first. The fourth byte is
// not stored; it is merged combinationally so the loader can register the
// complete word on the same edge that accepts that byte.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  byte_valid_i,
    input  logic [BYTE_WIDTH-1:0] byte_i,
    output logic [31:0]           word_o,
    output logic                  word_valid_o
);

    logic [23:0] shift_q;
    logic [23:0] shift_d;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;

    // Next shift/counter value: clear on frame start, shift on each byte
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = 24'd0;
            cnt_d   = 2'd0;
        end else if (byte_valid_i) begin
            shift_d = {shift_q[15:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
        end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
        end
    end

    // Assembler state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 24'd0;
            cnt_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream, writes big-endian words into
// program memory and holds the CPU in reset until a frame checks out.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 256,
    parameter logic [BYTE_WIDTH-1:0] HEADER_BYTE  = HEADER_BYTE_DEFAULT,
    localparam int                   ADDR_WIDTH   = $clog2(MEMORY_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BYTE_WIDTH-1:0]  rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic                   mem_write_o,
    output logic [ADDR_WIDTH-1:0]  mem_address_o,
    output logic [31:0]            mem_data_o,
    output logic                   cpu_hold_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [COUNT_WIDTH-1:0] loaded_words_o
);

    localparam logic [COUNT_WIDTH-1:0] MAX_WORDS = COUNT_WIDTH'(MEMORY_DEPTH);

    state_e                 state_q,     state_d;
    logic [COUNT_WIDTH-1:0] count_q,     count_d;
    logic [BYTE_WIDTH-1:0]  checksum_q,  checksum_d;
    logic [COUNT_WIDTH-1:0] loaded_q,    loaded_d;
    logic                   mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q,  mem_addr_d;
    logic [31:0]            mem_data_q,  mem_data_d;
    logic                   cpu_hold_q,  cpu_hold_d;
    logic                   done_q,      done_d;
    logic                   error_q,     error_d;
    logic                   rx_ready_q,  rx_ready_d;

    logic        byte_take_s;
    logic        is_header_s;
    logic        idle_like_s;
    logic        frame_start_s;
    logic        asm_valid_s;
    logic [31:0] asm_word_s;
    logic        asm_word_valid_s;

    // Handshake and frame-start decode kept outside the FSM block so the
    // assembler's completion flag never loops back into its own input.
    assign byte_take_s   = rx_valid_i && rx_ready_q;
    assign is_header_s   = (rx_data_i == HEADER_BYTE);
    assign idle_like_s   = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
    assign frame_start_s = byte_take_s && is_header_s && idle_like_s;
    assign asm_valid_s   = byte_take_s && (state_q == ST_DATA);

    word_assembler u_word_assembler (
        .clk          (clk),
        .rst_n        (reset),
        .clear_i      (frame_start_s),
        .byte_valid_i (asm_valid_s),
        .byte_i       (rx_data_i),
        .word_o       (asm_word_s),
        .word_valid_o (asm_word_valid_s)
    );

    // FSM next state, checksum, word counter, memory write and handshake
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        checksum_d  = checksum_q;
        loaded_d    = loaded_q;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;
        rx_ready_d  = 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (frame_start_s) begin
                    state_d    = ST_COUNT_HI;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    loaded_d   = {COUNT_WIDTH{1'b0}};
                    checksum_d = {BYTE_WIDTH{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_COUNT_HI: begin
                if (byte_take_s) begin
                    count_d = {rx_data_i, count_q[7:0]};
                    state_d = ST_COUNT_LO;
                end else begin
                    state_d = state_q;
                end
            end
            ST_COUNT_LO: begin
                if (byte_take_s) begin
                    count_d = {count_q[15:8], rx_data_i};
                    if (count_d > MAX_WORDS) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else if (count_d == {COUNT_WIDTH{1'b0}}) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA: begin
                if (mem_write_q) begin
                    // Write cycle: no byte accepted; leave once all N words are in.
                    if (loaded_q == count_q) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = state_q;
                    end
                end else if (byte_take_s) begin
                    checksum_d = checksum_q ^ rx_data_i;
                    if (asm_word_valid_s) begin
                        // loaded_q is the index of this word; it is < MEMORY_DEPTH
                        // here, so the address never wraps.
                        mem_write_d = 1'b1;
                        mem_addr_d  = loaded_q[ADDR_WIDTH-1:0];
                        mem_data_d  = asm_word_s;
                        loaded_d    = loaded_q + 16'd1;
                        rx_ready_d  = 1'b0;
                    end else begin
                        mem_write_d = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_CHECK: begin
                if (byte_take_s) begin
                    if (rx_data_i == checksum_q) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Loader registers; asynchronous reset aborts any frame in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_q     <= 16'd0;
            checksum_q  <= 8'd0;
            loaded_q    <= 16'd0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_data_q  <= 32'd0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            rx_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            checksum_q  <= checksum_d;
            loaded_q    <= loaded_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
            rx_ready_q  <= rx_ready_d;
        end
    end

    assign rx_ready_o     = rx_ready_q;
    assign mem_write_o    = mem_write_q;
    assign mem_address_o  = mem_addr_q;
    assign mem_data_o     = mem_data_q;
    assign cpu_hold_o     = cpu_hold_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign loaded_words_o = loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames with random
// payloads, checked against a frame-level model of expected writes.
module tb_program_loader;

    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data_i = 8'd0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic        mem_write_o;
    logic [7:0]  mem_address_o;
    logic [31:0] mem_data_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        error_o;
    logic [15:0] loaded_words_o;

    program_loader #(.MEMORY_DEPTH(256), .HEADER_BYTE(8'hA5)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_ready_o     (rx_ready_o),
        .mem_write_o    (mem_write_o),
        .mem_address_o  (mem_address_o),
        .mem_data_o     (mem_data_o),
        .cpu_hold_o     (cpu_hold_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .loaded_words_o (loaded_words_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    bit          mon_en = 1'b0;
    int          ready_bad = 0;
    int          wr_double = 0;
    logic        prev_wr = 1'b0;

    // Write monitor: records every memory write, flags stretched strobes and
    // any cycle where the loader stalls the stream without writing.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_write_o) begin
                wr_addr_q.push_back(int'(mem_address_o));
                wr_data_q.push_back(mem_data_o);
            end
            if (!rx_ready_o && !mem_write_o) ready_bad++;
            if (mem_write_o && prev_wr) wr_double++;
        end
        prev_wr = mem_write_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic wq_t rand_words(input int n);
        wq_t w;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        return w;
    endfunction

    // Reference checksum: XOR of every data byte of the frame
    function automatic logic [7:0] frame_chk(input wq_t w);
        logic [7:0] c = 8'd0;
        foreach (w[i]) c = c ^ w[i][31:24] ^ w[i][23:16] ^ w[i][15:8] ^ w[i][7:0];
        return c;
    endfunction

    // Present one byte (called at a negedge) and return at the negedge after it transfers
    task automatic send_byte(input logic [7:0] b, input bit thr);
        int guard = 0;
        if (thr) begin
            while ($urandom_range(0, 2) == 0) begin
                rx_valid_i = 1'b0;
                @(negedge clk);
            end
        end
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("rx_ready_timeout", 32'(rx_ready_o), 32'd1);
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    // Header, count and data bytes (checksum byte sent separately)
    task automatic send_frame(input logic [15:0] n, input wq_t w, input bit thr);
        logic [31:0] cur;
        send_byte(8'hA5, thr);
        send_byte(n[15:8], thr);
        send_byte(n[7:0], thr);
        foreach (w[i]) begin
            cur = w[i];
            for (int k = 3; k >= 0; k--) send_byte(cur[8*k +: 8], thr);
        end
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check_writes(input string tag, input wq_t w);
        chk({tag, "_wr_count"}, 32'(wr_data_q.size()), 32'(w.size()));
        for (int i = 0; i < w.size() && i < wr_data_q.size(); i++) begin
            chk({tag, "_wr_addr"}, 32'(wr_addr_q[i]), 32'(i));
            chk({tag, "_wr_data"}, wr_data_q[i], w[i]);
        end
    endtask

    // Full good frame plus result checks
    task automatic good_frame(input string tag, input wq_t w, input bit thr);
        clear_writes();
        send_frame(16'(w.size()), w, thr);
        chk({tag, "_hold_before_chk"}, 32'(cpu_hold_o), 32'd1);
        send_byte(frame_chk(w), thr);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_error"}, 32'(error_o), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold_o), 32'd0);
        chk({tag, "_loaded"}, 32'(loaded_words_o), 32'(w.size()));
        check_writes(tag, w);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(rx_ready_o), 32'd0);
        chk({tag, "_write"}, 32'(mem_write_o), 32'd0);
        chk({tag, "_addr"}, 32'(mem_address_o), 32'd0);
        chk({tag, "_data"}, mem_data_o, 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_error"}, 32'(error_o), 32'd0);
        chk({tag, "_loaded"}, 32'(loaded_words_o), 32'd0);
    endtask

    initial begin
        wq_t w;

        // Reset state and ready rising one clock after release
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        chk("ready_before_first_clk", 32'(rx_ready_o), 32'd0);
        @(negedge clk);
        chk("ready_after_first_clk", 32'(rx_ready_o), 32'd1);
        mon_en = 1'b1;

        // Nominal two-word frame
        w = {32'h20080005, 32'h01095020};
        good_frame("nominal", w, 1'b0);

        // Bad checksum: words still written, error flagged, CPU held
        clear_writes();
        send_frame(16'd2, w, 1'b0);
        send_byte(8'h54, 1'b0);
        @(negedge clk);
        chk("badchk_error", 32'(error_o), 32'd1);
        chk("badchk_done", 32'(done_o), 32'd0);
        chk("badchk_hold", 32'(cpu_hold_o), 32'd1);
        check_writes("badchk", w);
        good_frame("after_bad", rand_words(3), 1'b0);

        // Count overflow: N=257 aborts before any write
        clear_writes();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        @(negedge clk);
        chk("ovf_error", 32'(error_o), 32'd1);
        chk("ovf_done", 32'(done_o), 32'd0);
        chk("ovf_hold", 32'(cpu_hold_o), 32'd1);
        chk("ovf_loaded", 32'(loaded_words_o), 32'd0);
        chk("ovf_wr_count", 32'(wr_data_q.size()), 32'd0);

        // Empty frame
        w.delete();
        good_frame("empty", w, 1'b0);

        // Leading noise and random valid throttling
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h13, 1'b1);
        chk("noise_done_kept", 32'(done_o), 32'd1);
        good_frame("throttled", rand_words(4), 1'b1);

        // Asynchronous reset in the middle of word 1
        clear_writes();
        w = rand_words(2);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int k = 3; k >= 0; k--) send_byte(w[0][8*k +: 8], 1'b0);
        send_byte(w[1][31:24], 1'b0);
        send_byte(w[1][23:16], 1'b0);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check_all_zero("midreset");
        w.pop_back();
        check_writes("midreset_partial", w);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        good_frame("after_reset", rand_words(3), 1'b0);

        // Full-depth frame
        good_frame("depth256", rand_words(256), 1'b0);
        chk("depth256_last_addr", 32'(wr_addr_q[wr_addr_q.size()-1]), 32'd255);

        chk("ready_low_outside_write", 32'(ready_bad), 32'd0);
        chk("write_strobe_single_cycle", 32'(wr_double), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader. It is the writer for the instruction-memory read port that the MIPS_Processor fetch stage uses.
- Receives a framed program image over a valid/ready byte interface and assembles big-endian 32-bit words.
- Writes those words sequentially into program memory and holds the processor core in reset while loading.
- Sits between a UART receiver and the Program_Memory write port at the top level, beside MIPS_Processor.

Parameters:
- MEMORY_DEPTH, 256, number of 32-bit words in program memory; upper bound on the frame word count.
- HEADER_BYTE, 8'hA5, frame start marker.
- ADDR_WIDTH, $clog2(MEMORY_DEPTH), localparam; width of the word index.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data_i  input  8  incoming byte.
- rx_valid_i  input  1  rx_data_i valid.
- rx_ready_o  output  1  loader can accept a byte; transfer occurs on a rising edge with rx_valid_i & rx_ready_o.
- mem_write_o  output  1  one-cycle write strobe to program memory.
- mem_address_o  output  ADDR_WIDTH  word index for the write.
- mem_data_o  output  32  word to write.
- cpu_hold_o  output  1  held high to keep MIPS_Processor in reset.
- done_o  output  1  last frame loaded with a good checksum.
- error_o  output  1  last frame aborted (count overflow or checksum mismatch).
- loaded_words_o  output  16  words written in the current or last frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0, state IDLE, checksum 0, byte counter 0.
  - rx_ready_o rises to 1 on the first clock after reset release.
- Frame format: HEADER_BYTE, COUNT_HI, COUNT_LO, N×4 data bytes (MSB first per word), CHK.
  - N = {COUNT_HI, COUNT_LO}.
  - CHK = XOR of all data bytes only.
- States:
  - IDLE: accepts and discards any byte other than HEADER_BYTE. On HEADER_BYTE: go to COUNT_HI; set cpu_hold_o=1; clear done_o, error_o, loaded_words_o and the checksum.
  - COUNT_HI: latch the byte as N[15:8]; go to COUNT_LO.
  - COUNT_LO: latch N[7:0].
    - N > MEMORY_DEPTH: go to ERROR.
    - N == 0: go to CHECK.
    - Otherwise: go to DATA with word index 0.
  - DATA: shift bytes into a 32-bit assembler (first byte lands in [31:24]) and XOR each into the checksum. On the 4th byte of a word, the next cycle has:
    - mem_write_o=1
    - mem_data_o = assembled word
    - mem_address_o = word index
    - loaded_words_o incremented in the same cycle.
    - rx_ready_o=0 during that write cycle (one write per word, no overlap).
    - After the Nth write, go to CHECK.
  - CHECK: compare the accepted byte with the checksum. Equal: go to DONE. Unequal: go to ERROR.
  - DONE: done_o=1, cpu_hold_o=0 (registered, one cycle after the CHK byte).
  - ERROR: error_o=1, cpu_hold_o stays 1.
  - From DONE or ERROR, rx_ready_o=1. A HEADER_BYTE restarts the load as from IDLE; other bytes are discarded.
- mem_write_o is high for exactly one cycle per word and never outside DATA. mem_address_o and mem_data_o hold their last values otherwise.
- Words already written before an ERROR are not rolled back.
- No timeout. A stalled frame waits indefinitely with cpu_hold_o=1.
- A reset assertion mid-frame aborts immediately: no partial word is written and cpu_hold_o drops to 0.
- rx_valid_i low in any state: no state change.
- When N == MEMORY_DEPTH the final index is MEMORY_DEPTH-1; the index never wraps.

Decomposition:
- Shared package:
  - state enum (IDLE, COUNT_HI, COUNT_LO, DATA, CHECK, DONE, ERROR)
  - HEADER_BYTE default
  - frame field widths (COUNT_WIDTH=16, BYTE_WIDTH=8).
- Sub-module word_assembler:
  - 4-byte shift register plus a 2-bit byte counter.
  - Outputs word_o and a word_valid_o pulse.
  - Cleared on frame start.
- FSM, checksum, address counter and handshake live in program_loader.

Test Plan:
- Nominal: stream A5 00 02 20 08 00 05 01 09 50 20 55 → writes [0]=0x20080005 and [1]=0x01095020, each with a 1-cycle mem_write_o; loaded_words_o=2; done_o=1; cpu_hold_o 1→0 after the 55 byte.
- Bad checksum: same frame with CHK=0x54 → both words written; error_o=1; done_o=0; cpu_hold_o remains 1. A following good frame → done_o=1 and error_o cleared.
- Overflow/empty: A5 01 01 with MEMORY_DEPTH=256 → ERROR after COUNT_LO, zero writes. A5 00 00 00 → done_o=1, zero writes.
- Noise and throttling: bytes 00 FF 13 before A5, plus rx_valid_i toggled randomly throughout a 4-word frame → leading bytes ignored; words and addresses 0..3 correct; rx_ready_o low only in write cycles; no byte lost or duplicated.
- Reset mid-frame: reset=0 asynchronously after the 2nd data byte of word 1 → all outputs 0 immediately. After release, a full frame loads correctly from index 0.
- Boundary: N=256 with random data → 256 writes, last at index 255, no wrap, done_o=1.
